// File: rtl/mem_access_arbiter_if.sv
// Requester-side bundle for the SNN memory arbiter: two packed request channels
// (index 0 = NoC unpacker, index 1 = adder writeback) and their read-response channels.
interface mem_access_arbiter_if #(
  parameter int T_W    = 3,
  parameter int X_W    = 5,
  parameter int Y_W    = 5,
  parameter int DATA_W = 13
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*T_W-1:0]    req_t;
  logic [2*X_W-1:0]    req_x;
  logic [2*Y_W-1:0]    req_y;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [2*DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_t, req_x, req_y, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_t, req_x, req_y, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-requester arbiter for the single-port SNN memory: grant, registered command,
// fixed-latency read return into one-deep response buffers, out-of-range trapping.
// Define STRICT_PRIO_EN to give requester 1 absolute priority instead of round-robin.
module mem_access_arbiter #(
  parameter int T_W     = 3,
  parameter int X_W     = 5,
  parameter int Y_W     = 5,
  parameter int X_DIM   = 25,
  parameter int Y_DIM   = 25,
  parameter int DATA_W  = 13,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_arbiter_if.slave bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [T_W-1:0]    mem_t,
  output logic [X_W-1:0]    mem_x,
  output logic [Y_W-1:0]    mem_y,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_oor
);

  logic [1:0]        rd_pend;   // read accepted, response not yet in the buffer
  logic [1:0]        rsp_full;
  logic [1:0]        elig;
  logic [1:0]        gnt;
  logic              gnt_any;
  logic              gnt_id;

  logic              sel_we;
  logic              sel_oor;
  logic [T_W-1:0]    sel_t;
  logic [X_W-1:0]    sel_x;
  logic [Y_W-1:0]    sel_y;
  logic [DATA_W-1:0] sel_wdata;

  logic              rd_issue;
  logic              rd_id;
  logic              rd_oor;

  logic              pipe_v   [MEM_LAT];
  logic              pipe_id  [MEM_LAT];
  logic              pipe_oor [MEM_LAT];
  logic              ret_oor;
  logic [1:0]        load;
  logic [DATA_W-1:0] rsp_buf  [2];

  // A requester with a read outstanding (in flight or buffered) may still write.
  assign elig = bus.req_valid & (bus.req_we | ~(rd_pend | rsp_full));

`ifdef STRICT_PRIO_EN
  always_comb begin
    gnt = 2'b00;
    if (elig[1])      gnt = 2'b10;
    else if (elig[0]) gnt = 2'b01;
  end
`else
  logic rr_ptr;

  always_comb begin
    // NOTE: default assigned first so every path drives gnt and no latch is inferred.
    gnt = 2'b00;
    case (elig)
      2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
      2'b10:   gnt = 2'b10;
      2'b01:   gnt = 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_ptr <= 1'b0;
    else if (gnt_any) rr_ptr <= ~gnt_id;
  end
`endif

  assign gnt_any       = |gnt;
  assign gnt_id        = gnt[1];
  assign bus.req_ready = gnt;

  assign sel_we    = bus.req_we[gnt_id];
  assign sel_t     = gnt_id ? bus.req_t[T_W +: T_W]             : bus.req_t[0 +: T_W];
  assign sel_x     = gnt_id ? bus.req_x[X_W +: X_W]             : bus.req_x[0 +: X_W];
  assign sel_y     = gnt_id ? bus.req_y[Y_W +: Y_W]             : bus.req_y[0 +: Y_W];
  assign sel_wdata = gnt_id ? bus.req_wdata[DATA_W +: DATA_W]   : bus.req_wdata[0 +: DATA_W];
  assign sel_oor   = (32'(sel_x) >= X_DIM) || (32'(sel_y) >= Y_DIM);

  // Registered memory command; out-of-range requests never strobe the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_t     <= '0;
      mem_x     <= '0;
      mem_y     <= '0;
      mem_wdata <= '0;
      rd_issue  <= 1'b0;
      rd_id     <= 1'b0;
      rd_oor    <= 1'b0;
      err_oor   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      mem_en   <= gnt_any & ~sel_oor;
      mem_we   <= gnt_any & ~sel_oor & sel_we;
      rd_issue <= gnt_any & ~sel_we;
      if (gnt_any) begin
        mem_t     <= sel_t;
        mem_x     <= sel_x;
        mem_y     <= sel_y;
        mem_wdata <= sel_wdata;
        rd_id     <= gnt_id;
        rd_oor    <= sel_oor;
      end
      if (gnt_any && sel_oor) err_oor <= 1'b1;
    end
  end

  // Read-return tracker: one stage per cycle of memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: pipeline and buffers are reset so no in-flight read survives a reset.
      for (int k = 0; k < MEM_LAT; k++) begin
        pipe_v[k]   <= 1'b0;
        pipe_id[k]  <= 1'b0;
        pipe_oor[k] <= 1'b0;
      end
    end else begin
      pipe_v[0]   <= rd_issue;
      pipe_id[0]  <= rd_id;
      pipe_oor[0] <= rd_oor;
      for (int k = 1; k < MEM_LAT; k++) begin
        pipe_v[k]   <= pipe_v[k-1];
        pipe_id[k]  <= pipe_id[k-1];
        pipe_oor[k] <= pipe_oor[k-1];
      end
    end
  end

  assign ret_oor = pipe_oor[MEM_LAT-1];
  assign load    = pipe_v[MEM_LAT-1] ? (pipe_id[MEM_LAT-1] ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend    <= 2'b00;
      rsp_full   <= 2'b00;
      rsp_buf[0] <= '0;
      rsp_buf[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (gnt[i] && !bus.req_we[i]) rd_pend[i] <= 1'b1;
        else if (load[i])             rd_pend[i] <= 1'b0;

        if (load[i]) begin
          rsp_full[i] <= 1'b1;
          rsp_buf[i]  <= ret_oor ? '0 : mem_rdata;
        end else if (bus.rsp_ready[i]) begin
          rsp_full[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_full;
  assign bus.rsp_data  = {rsp_buf[1], rsp_buf[0]};

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level reference model.
module tb_mem_access_arbiter;

  localparam int T_W     = 3;
  localparam int X_W     = 5;
  localparam int Y_W     = 5;
  localparam int X_DIM   = 25;
  localparam int Y_DIM   = 25;
  localparam int DATA_W  = 13;
  localparam int MEM_LAT = 1;
  localparam int DEPTH   = 1 << (T_W + X_W + Y_W);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_en;
  logic              mem_we;
  logic [T_W-1:0]    mem_t;
  logic [X_W-1:0]    mem_x;
  logic [Y_W-1:0]    mem_y;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              err_oor;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_arbiter_if #(.T_W(T_W), .X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W)) bus ();

  mem_access_arbiter #(
    .T_W(T_W), .X_W(X_W), .Y_W(Y_W), .X_DIM(X_DIM), .Y_DIM(Y_DIM),
    .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_t(mem_t), .mem_x(mem_x), .mem_y(mem_y),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_oor(err_oor)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-port memory with one cycle of read latency.
  logic [DATA_W-1:0] env_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) env_mem[i] = DATA_W'(i * 37 + 5);
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) env_mem[{mem_t, mem_x, mem_y}] <= mem_wdata;
        else        mem_rdata <= env_mem[{mem_t, mem_x, mem_y}];
      end
    end
  end

  // Reference model: tracks accepted transactions, not the DUT's internal pipeline.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                cyc;
  bit                m_busy [2];
  int                m_due  [2];
  logic [DATA_W-1:0] m_rd   [2];
  int                m_rr;
  bit                m_en, m_we, m_err;
  logic [T_W-1:0]    m_t;
  logic [X_W-1:0]    m_x;
  logic [Y_W-1:0]    m_y;
  logic [DATA_W-1:0] m_wd;

  initial begin
    bit elig [2];
    bit rv   [2];
    int g;
    logic [T_W-1:0]    t;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [DATA_W-1:0] d;
    bit we, oor;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'(i * 37 + 5);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = '{0, 0};
        m_rr   = 0;
        m_en   = 0;
        m_we   = 0;
        m_err  = 0;
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_data",  32'(bus.rsp_data), 0);
        check("rst_mem_cmd",   32'({mem_en, mem_we, mem_t, mem_x, mem_y}), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_err_oor",   32'(err_oor), 0);
      end else begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
          rv[i]   = m_busy[i] && (cyc >= m_due[i]);
          elig[i] = bus.req_valid[i] && (bus.req_we[i] || !m_busy[i]);
        end
`ifdef STRICT_PRIO_EN
        if (elig[1])      g = 1;
        else if (elig[0]) g = 0;
        else              g = -1;
`else
        if (elig[0] && elig[1]) g = m_rr;
        else if (elig[0])       g = 0;
        else if (elig[1])       g = 1;
        else                    g = -1;
`endif
        check("req_ready", 32'(bus.req_ready), (g < 0) ? 0 : (1 << g));
        check("rsp_valid", 32'(bus.rsp_valid), {30'b0, rv[1], rv[0]});
        for (int i = 0; i < 2; i++)
          if (rv[i]) check($sformatf("rsp_data%0d", i), 32'(bus.rsp_data[i*DATA_W +: DATA_W]), 32'(m_rd[i]));
        check("mem_en", 32'(mem_en), 32'(m_en));
        if (m_en) begin
          check("mem_we",   32'(mem_we), 32'(m_we));
          check("mem_addr", 32'({mem_t, mem_x, mem_y}), 32'({m_t, m_x, m_y}));
          if (m_we) check("mem_wdata", 32'(mem_wdata), 32'(m_wd));
        end
        check("err_oor", 32'(err_oor), 32'(m_err));

        // Advance to the next cycle.
        for (int i = 0; i < 2; i++)
          if (rv[i] && bus.rsp_ready[i]) m_busy[i] = 0;
        m_en = 0;
        m_we = 0;
        if (g >= 0) begin
          we  = bus.req_we[g];
          t   = bus.req_t[g*T_W +: T_W];
          x   = bus.req_x[g*X_W +: X_W];
          y   = bus.req_y[g*Y_W +: Y_W];
          d   = bus.req_wdata[g*DATA_W +: DATA_W];
          oor = (int'(x) >= X_DIM) || (int'(y) >= Y_DIM);
          if (oor) m_err = 1;
          else begin
            m_en = 1; m_we = we; m_t = t; m_x = x; m_y = y; m_wd = d;
          end
          if (!we) begin
            m_busy[g] = 1;
            m_due[g]  = cyc + MEM_LAT + 2;
            m_rd[g]   = oor ? '0 : ref_mem[{t, x, y}];
          end else if (!oor) begin
            ref_mem[{t, x, y}] = d;
          end
          m_rr = (g == 0) ? 1 : 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_t     = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_wdata = '0;
  endtask

  task automatic set_req(input int i, input bit we, input logic [T_W-1:0] t,
                         input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                         input logic [DATA_W-1:0] d);
    bus.req_valid[i]                 = 1'b1;
    bus.req_we[i]                    = we;
    bus.req_t[i*T_W +: T_W]          = t;
    bus.req_x[i*X_W +: X_W]          = x;
    bus.req_y[i*Y_W +: Y_W]          = y;
    bus.req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    idle_req();
    bus.rsp_ready = '0;
    step();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_req();
    bus.rsp_ready = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write t=2,x=3,y=4,0x155 from requester 0.
    set_req(0, 1'b1, 3'd2, 5'd3, 5'd4, 13'h155);
    @(negedge clk); check("t1_ready", 32'(bus.req_ready), 1);
    step(); idle_req();
    @(negedge clk);
    check("t1_mem_en",    32'(mem_en), 1);
    check("t1_mem_we",    32'(mem_we), 1);
    check("t1_mem_addr",  32'({mem_t, mem_x, mem_y}), 32'({3'd2, 5'd3, 5'd4}));
    check("t1_mem_wdata", 32'(mem_wdata), 'h155);
    check("t1_no_rsp",    32'(bus.rsp_valid), 0);

    // Read back the same word: response at N+3.
    step(); set_req(0, 1'b0, 3'd2, 5'd3, 5'd4, '0);
    @(negedge clk); check("t2_ready", 32'(bus.req_ready), 1);
    step(); idle_req();
    @(negedge clk); check("t2_mem_rd", 32'({mem_en, mem_we}), 2);
    step();
    @(negedge clk); check("t2_rsp_early", 32'(bus.rsp_valid), 0);
    step();
    @(negedge clk);
    check("t2_rsp_valid", 32'(bus.rsp_valid), 1);
    check("t2_rsp_data",  32'(bus.rsp_data[0 +: DATA_W]), 'h155);
    step(); bus.rsp_ready = 2'b01;
    @(negedge clk); check("t2_rsp_hold", 32'(bus.rsp_valid), 1);
    step(); bus.rsp_ready = 2'b00;
    @(negedge clk); check("t2_rsp_popped", 32'(bus.rsp_valid), 0);

    // Both requesters stream writes from reset.
    do_reset();
    set_req(0, 1'b1, 3'd0, 5'd5, 5'd5, 13'h001);
    set_req(1, 1'b1, 3'd0, 5'd6, 5'd6, 13'h002);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
`ifdef STRICT_PRIO_EN
      check("t3_grant", 32'(bus.req_ready), 2);
`else
      check("t3_grant", 32'(bus.req_ready), (k % 2 == 0) ? 1 : 2);
`endif
      step();
    end
    bus.req_valid[1] = 1'b0;
    @(negedge clk); check("t3_req1_drop", 32'(bus.req_ready), 1);
    step(); idle_req();

    // Requester 1 read stalls on a full response buffer while requester 0 keeps writing.
    set_req(1, 1'b0, 3'd0, 5'd1, 5'd1, '0);
    @(negedge clk); check("t4_first", 32'(bus.req_ready), 2);
    step(); set_req(0, 1'b1, 3'd1, 5'd2, 5'd2, 13'h0AA);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); check("t4_hold", 32'(bus.req_ready), 1);
      step();
    end
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    check("t4_pop_cycle",  32'(bus.req_ready), 1);
    check("t4_rsp1_valid", 32'(bus.rsp_valid), 2);
    step(); bus.rsp_ready = 2'b00;
    @(negedge clk); check("t4_after_pop", 32'(bus.req_ready), 2);
    step(); idle_req(); bus.rsp_ready = 2'b11;
    repeat (6) step();
    bus.rsp_ready = 2'b00;

    // Out-of-range read, then out-of-range write.
    do_reset();
    set_req(0, 1'b0, 3'd0, 5'd25, 5'd0, '0);
    @(negedge clk);
    check("t5_ready",   32'(bus.req_ready), 1);
    check("t5_err_pre", 32'(err_oor), 0);
    step(); idle_req();
    @(negedge clk);
    check("t5_mem_en", 32'(mem_en), 0);
    check("t5_err",    32'(err_oor), 1);
    step(); step();
    @(negedge clk);
    check("t5_rsp_valid", 32'(bus.rsp_valid), 1);
    check("t5_rsp_data",  32'(bus.rsp_data[0 +: DATA_W]), 0);
    step(); bus.rsp_ready = 2'b01;
    step(); bus.rsp_ready = 2'b00; set_req(1, 1'b1, 3'd0, 5'd0, 5'd31, 13'h007);
    @(negedge clk); check("t5_wr_ready", 32'(bus.req_ready), 2);
    step(); idle_req();
    @(negedge clk);
    check("t5_wr_mem_en", 32'(mem_en), 0);
    check("t5_err_sticky", 32'(err_oor), 1);

    // Reset one cycle after a read is accepted.
    step(); set_req(0, 1'b0, 3'd0, 5'd7, 5'd7, '0);
    @(negedge clk); check("t6_ready", 32'(bus.req_ready), 1);
    step(); rst_n = 1'b0; idle_req();
    @(negedge clk);
    check("t6_rst_rsp", 32'(bus.rsp_valid), 0);
    check("t6_rst_mem", 32'({mem_en, mem_we}), 0);
    check("t6_rst_err", 32'(err_oor), 0);
    step(); step(); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); check("t6_no_late_rsp", 32'(bus.rsp_valid), 0);
      step();
    end
    set_req(0, 1'b1, 3'd0, 5'd8, 5'd8, 13'h011);
    set_req(1, 1'b1, 3'd0, 5'd9, 5'd9, 13'h022);
    @(negedge clk);
`ifdef STRICT_PRIO_EN
    check("t6_first_grant", 32'(bus.req_ready), 2);
`else
    check("t6_first_grant", 32'(bus.req_ready), 1);
`endif
    step(); idle_req();

    // Randomized traffic over a small address window to provoke read-after-write reuse.
    repeat (3000) begin
      step();
      for (int i = 0; i < 2; i++) begin
        bus.req_valid[i] = ($urandom_range(0, 9) < 7);
        set_req(i, 1'($urandom_range(0, 1)), T_W'($urandom_range(0, 1)),
                X_W'(($urandom_range(0, 99) < 4) ? $urandom_range(25, 31) : $urandom_range(0, 3)),
                Y_W'(($urandom_range(0, 99) < 4) ? $urandom_range(25, 31) : $urandom_range(0, 3)),
                DATA_W'($urandom));
        bus.req_valid[i] = ($urandom_range(0, 9) < 7);
        bus.rsp_ready[i] = ($urandom_range(0, 9) < 6);
      end
    end
    step(); idle_req(); bus.rsp_ready = 2'b11;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
